// File: rtl/modulo_mux35_1_scanner_pkg.sv
// Shared constants and state encoding for the 35:1 line scanner.
// The 1:35 demux side imports the same index map.
package modulo_mux35_1_scanner_pkg;

  localparam int N_LINES = 35;
  localparam int SEL_W = 6;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_LINES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    EMIT = 2'b10
  } state_t;

  // Select k addresses line bit N_LINES-1-k.
  function automatic logic [SEL_W-1:0] line_of(
    input logic [SEL_W-1:0] sel
  );
    return LAST_SEL - sel;
  endfunction

endpackage

// File: rtl/modulo_sync2.sv
// Parameterized-width two-flop synchronizer.
// Both stages clear on reset.
module modulo_sync2
  import modulo_mux35_1_scanner_pkg::*;
#(
  parameter int W = N_LINES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/modulo_mux35_1_scanner.sv
// Sequential 35:1 line scanner emitting one valid/ready event per
// level change, in scan order.
module modulo_mux35_1_scanner #(
  parameter int N_LINES = modulo_mux35_1_scanner_pkg::N_LINES,
  parameter int SEL_W   = modulo_mux35_1_scanner_pkg::SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] in_lines,
  input  logic               enable,
  output logic [SEL_W-1:0]   scan_sel,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [SEL_W-1:0]   evt_sel,
  output logic               evt_level,
  output logic               frame_done
);

  import modulo_mux35_1_scanner_pkg::*;

  localparam logic [SEL_W-1:0] SEL_END = SEL_W'(N_LINES - 1);

  state_t             state;
  logic [N_LINES-1:0] in_sync;
  logic [N_LINES-1:0] prev;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   sel_next;
  logic               cur;
  logic               wrap;
  logic               bad_sel;

  modulo_sync2 #(
    .W (N_LINES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_lines),
    .q   (in_sync)
  );

  always_comb begin
    idx      = SEL_END - scan_sel;
    cur      = in_sync[idx];
    wrap     = (scan_sel == SEL_END);
    sel_next = wrap ? '0 : scan_sel + SEL_W'(1);
    bad_sel  = (scan_sel > SEL_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      scan_sel   <= '0;
      prev       <= '0;
      evt_valid  <= 1'b0;
      evt_sel    <= '0;
      evt_level  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          scan_sel <= '0;
          if (enable) state <= SCAN;
        end
        SCAN: begin
          if (bad_sel) begin
            state    <= IDLE;
            scan_sel <= '0;
          end else if (cur != prev[idx]) begin
            prev[idx] <= cur;
            evt_sel   <= scan_sel;
            evt_level <= cur;
            evt_valid <= 1'b1;
            state     <= EMIT;
          end else begin
            frame_done <= wrap;
            scan_sel   <= enable ? sel_next : '0;
            state      <= enable ? SCAN : IDLE;
          end
        end
        EMIT: begin
          if (bad_sel) begin
            state     <= IDLE;
            scan_sel  <= '0;
            evt_valid <= 1'b0;
          end else if (evt_ready) begin
            // enable is only honoured once the event is delivered
            evt_valid  <= 1'b0;
            frame_done <= wrap;
            scan_sel   <= enable ? sel_next : '0;
            state      <= enable ? SCAN : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          scan_sel  <= '0;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_mux35_1_scanner.sv
// Scoreboard bench for the 35:1 scanner: a level model predicts
// the event stream, a monitor checks every handshake.
module tb_modulo_mux35_1_scanner;

  localparam int N = 35;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         evt_ready;
  logic [N-1:0] in_lines;
  logic [5:0]   scan_sel;
  logic [5:0]   evt_sel;
  logic         evt_valid;
  logic         evt_level;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sel;
    bit level;
  } evt_t;

  evt_t exp_q[$];
  bit   seen[N];
  bit   ready_rand = 1'b0;

  always #5 clk = ~clk;

  modulo_mux35_1_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .in_lines   (in_lines),
    .enable     (enable),
    .scan_sel   (scan_sel),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_sel    (evt_sel),
    .evt_level  (evt_level),
    .frame_done (frame_done)
  );

  always @(posedge clk) begin
    #1;
    if (ready_rand) evt_ready = ($urandom_range(0, 3) != 0);
  end

  // Values seen at negedge are those presented at the next posedge.
  always @(negedge clk) begin
    evt_t e;
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got sel=%0d level=%0d, wanted none",
                 evt_sel, evt_level);
      end else begin
        e = exp_q.pop_front();
        if (evt_sel != 6'(e.sel) || evt_level != e.level) begin
          errors++;
          $display("FAIL event: got sel=%0d level=%0d, wanted sel=%0d level=%0d",
                   evt_sel, evt_level, e.sel, e.level);
        end
      end
    end
  end

  // Reference: while idle, every select whose level differs from the
  // last reported level yields one event, ascending from select 0.
  task automatic set_lines(input logic [N-1:0] v);
    in_lines = v;
    for (int k = 0; k < N; k++) begin
      if (v[N-1-k] != seen[k]) begin
        exp_q.push_back('{sel: k, level: v[N-1-k]});
        seen[k] = v[N-1-k];
      end
    end
  endtask

  task automatic go_idle();
    int n;
    int run;
    n = 0;
    run = 0;
    @(posedge clk);
    #1 enable = 1'b0;
    while (run < 2 && n < 300) begin
      @(negedge clk);
      n++;
      if (scan_sel == 0 && !evt_valid) run++;
      else run = 0;
    end
    if (run < 2) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got scan_sel=%0d valid=%0d, wanted idle",
               scan_sel, evt_valid);
    end
  endtask

  task automatic run_drain();
    int n;
    n = 0;
    @(posedge clk);
    #1 enable = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events pending, wanted 0", exp_q.size());
      exp_q.delete();
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic apply(input logic [N-1:0] v);
    go_idle();
    set_lines(v);
    repeat (4) @(posedge clk);
    run_drain();
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!evt_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = evt_valid;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got valid=0, wanted 1");
    end
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_done && cyc < 200);
  endtask

  logic [N-1:0] m;
  int           cyc;
  int           bad;
  bit           ok;
  logic [5:0]   s0;
  logic [5:0]   e0;

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, wanted finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    evt_ready = 1'b1;
    in_lines  = '0;
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({scan_sel, evt_valid, evt_sel, evt_level, frame_done} != '0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%0d v=%0d es=%0d lv=%0d fd=%0d, wanted 0",
               scan_sel, evt_valid, evt_sel, evt_level, frame_done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;

    // Quiet lines: fixed 35-cycle frame, select counts 0..34.
    wait_frame(cyc);
    for (int f = 0; f < 3; f++) begin
      bad = 0;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (cyc < 35 && scan_sel != 6'(cyc)) bad++;
      end while (!frame_done && cyc < 200);
      checks++;
      if (cyc != 35 || bad != 0) begin
        errors++;
        $display("FAIL frame_period: got %0d cycles (%0d sel errs), wanted 35",
                 cyc, bad);
      end
    end

    ready_rand = 1'b1;
    m = '0;
    m[34] = 1'b1;
    apply(m);
    apply('0);
    m = '0;
    m[0] = 1'b1;
    apply(m);
    m[33] = 1'b1;
    m[32] = 1'b1;
    apply(m);

    // Backpressure: event and select hold while ready is low.
    go_idle();
    ready_rand = 1'b0;
    evt_ready  = 1'b0;
    m = in_lines;
    m[29] = ~m[29];
    set_lines(m);
    repeat (4) @(posedge clk);
    #1 enable = 1'b1;
    wait_valid(ok);
    if (ok) begin
      s0  = scan_sel;
      e0  = evt_sel;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!evt_valid || evt_sel != e0 || scan_sel != s0) bad++;
      end
      checks++;
      if (bad != 0 || s0 != 6'd5) begin
        errors++;
        $display("FAIL stall_stable: got %0d unstable cycles sel=%0d, wanted 0 at sel=5",
                 bad, s0);
      end
      @(posedge clk);
      #1 evt_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (scan_sel != 6'd6 || evt_valid) begin
        errors++;
        $display("FAIL stall_resume: got sel=%0d valid=%0d, wanted sel=6 valid=0",
                 scan_sel, evt_valid);
      end
    end
    ready_rand = 1'b1;
    run_drain();

    for (int r = 0; r < 12; r++) begin
      m = in_lines;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) m[k] = ~m[k];
      apply(m);
    end

    // Reset while an event is pending.
    go_idle();
    ready_rand = 1'b0;
    evt_ready  = 1'b0;
    m = ~in_lines;
    m[0] = 1'b1;
    set_lines(m);
    repeat (4) @(posedge clk);
    #1 enable = 1'b1;
    wait_valid(ok);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({scan_sel, evt_valid, evt_sel, evt_level, frame_done} != '0) begin
      errors++;
      $display("FAIL reset_mid_emit: got sel=%0d v=%0d es=%0d lv=%0d fd=%0d, wanted 0",
               scan_sel, evt_valid, evt_sel, evt_level, frame_done);
    end
    enable = 1'b0;
    exp_q.delete();
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    set_lines(in_lines);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    ready_rand = 1'b1;
    run_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
